// File: rtl/tff_bank_pkg.sv
// Shared mode encoding for the tff_bank toggle flip-flop bank.
package tff_bank_pkg;

    typedef enum logic [1:0] {
        TFF_HOLD   = 2'd0,
        TFF_TOGGLE = 2'd1,
        TFF_LOAD   = 2'd2,
        TFF_COUNT  = 2'd3
    } tff_mode_e;

endpackage

// File: rtl/tff_bank_tff_cell.sv
// Single state bit with async clear, sync clear, parallel load and toggle.
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic clear_n,
    input  logic sclr,
    input  logic toggle,
    input  logic load_en,
    input  logic load_val,
    output logic q
);

    logic r_q;

    // Load outranks toggle, so one bit never needs both controls resolved elsewhere.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            r_q <= RST_BIT;
        else if (sclr)
            r_q <= RST_BIT;
        else if (load_en)
            r_q <= load_val;
        else if (toggle)
            r_q <= ~r_q;
    end

    assign q = r_q;

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops with hold/toggle/load/count modes and a wrap pulse.
// Define TFF_BANK_EDGE_EN to add registered-history rise/fall edge outputs.
module tff_bank
    import tff_bank_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sclr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
`ifdef TFF_BANK_EDGE_EN
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             wrap
);

    tff_mode_e        w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_load_en;
    logic             w_count_wrap;
    logic             r_wrap;

    assign w_mode = tff_mode_e'(mode);

    // Bit i of a binary count toggles when every lower bit is already one.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign w_carry[i] = 1'b1;
        end else begin : g_upper
            assign w_carry[i] = &w_q[i-1:0];
        end

        tff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk      (clk),
            .clear_n  (clear_n),
            .sclr     (sclr),
            .toggle   (w_toggle[i]),
            .load_en  (w_load_en[i]),
            .load_val (d[i]),
            .q        (w_q[i])
        );
    end

    always_comb begin
        w_toggle     = '0;
        w_load_en    = '0;
        w_count_wrap = 1'b0;
        if (en) begin
            case (w_mode)
                TFF_TOGGLE: w_toggle = t;
                TFF_LOAD:   w_load_en = '1;
                TFF_COUNT: begin
                    w_toggle     = w_carry;
                    w_count_wrap = &w_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            r_wrap <= 1'b0;
        else if (sclr)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_count_wrap;
    end

`ifdef TFF_BANK_EDGE_EN
    logic [WIDTH-1:0] r_q_prev;

    // History resets to the same value as q so no edge appears after reset.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            r_q_prev <= RST_VAL;
        else
            r_q_prev <= w_q;
    end

    assign rise = w_q & ~r_q_prev;
    assign fall = ~w_q & r_q_prev;
`endif

    assign q    = w_q;
    assign qn   = ~w_q;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_tff_bank.sv
// Self-checking bench for tff_bank: an 8-bit bank (RST_VAL=A5) and a 1-bit bank.
module tb_tff_bank;

    logic       clk;
    logic       clear_n;
    logic       sclr, en;
    logic [1:0] mode;
    logic [7:0] t, d;
    logic [7:0] q, qn;
    logic       wrap;
    logic       sclr1, en1;
    logic [1:0] mode1;
    logic       t1, d1;
    logic       q1, qn1, wrap1;
`ifdef TFF_BANK_EDGE_EN
    logic [7:0] rise, fall;
    logic       rise1, fall1;
`endif

    int total = 0;
    int bad   = 0;
    bit checkOn = 0;

    logic [7:0] mq;
    logic       mw;
    logic [7:0] mPrev;
    logic [7:0] m1q;
    logic       m1w;
    logic [7:0] m1Prev;

    tff_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .clk(clk), .clear_n(clear_n), .sclr(sclr), .en(en), .mode(mode),
        .t(t), .d(d),
`ifdef TFF_BANK_EDGE_EN
        .rise(rise), .fall(fall),
`endif
        .q(q), .qn(qn), .wrap(wrap)
    );

    tff_bank #(.WIDTH(1)) dut1 (
        .clk(clk), .clear_n(clear_n), .sclr(sclr1), .en(en1), .mode(mode1),
        .t(t1), .d(d1),
`ifdef TFF_BANK_EDGE_EN
        .rise(rise1), .fall(fall1),
`endif
        .q(q1), .qn(qn1), .wrap(wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next {wrap, q} from the mode rules using plain modular arithmetic.
    function automatic logic [8:0] nextOf(input int width, input logic [7:0] cur,
                                          input logic [7:0] rst, input logic sc,
                                          input logic e, input logic [1:0] m,
                                          input logic [7:0] tt, input logic [7:0] dd);
        int mx;
        int nq;
        mx = (1 << width) - 1;
        if (sc) return {1'b0, rst};
        if (!e) return {1'b0, cur};
        case (m)
            2'd1: nq = (int'(cur) ^ int'(tt)) & mx;
            2'd2: nq = int'(dd) & mx;
            2'd3: nq = (int'(cur) + 1) % (mx + 1);
            default: nq = int'(cur);
        endcase
        return {(m == 2'd3) && (int'(cur) == mx), nq[7:0]};
    endfunction

    always @(posedge clk or negedge clear_n) begin
        logic [8:0] n8;
        logic [8:0] n1;
        if (!clear_n) begin
            mq = 8'hA5; mw = 1'b0; mPrev = 8'hA5;
            m1q = 8'h00; m1w = 1'b0; m1Prev = 8'h00;
        end else begin
            n8 = nextOf(8, mq, 8'hA5, sclr, en, mode, t, d);
            n1 = nextOf(1, m1q, 8'h00, sclr1, en1, mode1, {7'b0, t1}, {7'b0, d1});
            mPrev = mq;
            m1Prev = m1q;
            mq = n8[7:0]; mw = n8[8];
            m1q = n1[7:0]; m1w = n1[8];
        end
    end

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkVal("q", q, mq);
            checkVal("qn", qn, ~mq);
            checkVal("wrap", {7'b0, wrap}, {7'b0, mw});
            checkVal("q1", {7'b0, q1}, m1q);
            checkVal("qn1", {7'b0, qn1}, {7'b0, ~m1q[0]});
            checkVal("wrap1", {7'b0, wrap1}, {7'b0, m1w});
`ifdef TFF_BANK_EDGE_EN
            checkVal("rise", rise, mq & ~mPrev);
            checkVal("fall", fall, ~mq & mPrev);
            checkVal("rise1", {7'b0, rise1}, {7'b0, m1q[0] & ~m1Prev[0]});
            checkVal("fall1", {7'b0, fall1}, {7'b0, ~m1q[0] & m1Prev[0]});
`endif
        end
    end

    task automatic applyStimulus(input logic s, input logic e, input logic [1:0] m,
                                 input logic [7:0] tt, input logic [7:0] dd);
        @(negedge clk);
        sclr = s; en = e; mode = m; t = tt; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expQ, input logic expW);
        checkVal({name, "_q"}, q, expQ);
        checkVal({name, "_wrap"}, {7'b0, wrap}, {7'b0, expW});
    endtask

    initial begin
        clear_n = 1'b0;
        sclr = 0; en = 0; mode = 0; t = 0; d = 0;
        sclr1 = 0; en1 = 0; mode1 = 0; t1 = 0; d1 = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 8'hA5, 1'b0);
        checkVal("reset_q1", {7'b0, q1}, 8'h00);
        clear_n = 1'b1;
        checkOn = 1;

        applyStimulus(0, 1, 2'd2, 8'h00, 8'h00);
        checkOutput("load00", 8'h00, 1'b0);
        applyStimulus(0, 1, 2'd1, 8'h0F, 8'h55);
        checkOutput("tog1", 8'h0F, 1'b0);
        applyStimulus(0, 1, 2'd1, 8'h0F, 8'h55);
        checkOutput("tog2", 8'h00, 1'b0);
        applyStimulus(0, 0, 2'd1, 8'h0F, 8'h55);
        checkOutput("enoff", 8'h00, 1'b0);

        applyStimulus(0, 1, 2'd2, 8'h00, 8'hFE);
        checkOutput("loadFE", 8'hFE, 1'b0);
        applyStimulus(0, 1, 2'd3, 8'hFF, 8'h00);
        checkOutput("cnt1", 8'hFF, 1'b0);
        applyStimulus(0, 1, 2'd3, 8'hFF, 8'h00);
        checkOutput("cnt2", 8'h00, 1'b1);
        applyStimulus(0, 1, 2'd3, 8'hFF, 8'h00);
        checkOutput("cnt3", 8'h01, 1'b0);

        applyStimulus(0, 1, 2'd2, 8'h00, 8'hFF);
        applyStimulus(1, 1, 2'd3, 8'h00, 8'h00);
        checkOutput("sclrwrap", 8'hA5, 1'b0);
        applyStimulus(0, 1, 2'd2, 8'h00, 8'h12);
        applyStimulus(1, 0, 2'd2, 8'h00, 8'h34);
        checkOutput("sclrnoen", 8'hA5, 1'b0);
        applyStimulus(0, 1, 2'd1, 8'hA5, 8'h00);
        checkOutput("togzero", 8'h00, 1'b0);

`ifdef TFF_BANK_EDGE_EN
        applyStimulus(0, 1, 2'd2, 8'h00, 8'h00);
        applyStimulus(0, 0, 2'd0, 8'h00, 8'h00);
        applyStimulus(0, 1, 2'd1, 8'h81, 8'h00);
        checkVal("edge_rise", rise, 8'h81);
        checkVal("edge_fall0", fall, 8'h00);
        applyStimulus(0, 0, 2'd0, 8'h00, 8'h00);
        checkVal("edge_rise_gone", rise, 8'h00);
        applyStimulus(0, 1, 2'd1, 8'h81, 8'h00);
        checkVal("edge_fall", fall, 8'h81);
        checkVal("edge_rise0", rise, 8'h00);
`endif

        // Mid-cycle async reset must take effect without a clock edge.
        applyStimulus(0, 1, 2'd2, 8'h00, 8'h3C);
        checkOutput("pre_rst", 8'h3C, 1'b0);
        #2 clear_n = 1'b0;
        #1 checkOutput("async_rst", 8'hA5, 1'b0);
        @(negedge clk);
        clear_n = 1'b1;

        en = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            en1 = 1; mode1 = 2'd3; t1 = 0; d1 = 1; sclr1 = 0;
            @(posedge clk);
            #1;
            checkVal("w1_q", {7'b0, q1}, 8'((k + 1) % 2));
            checkVal("w1_wrap", {7'b0, wrap1}, {7'b0, ((k + 1) % 2) == 0});
        end

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            sclr  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = ($urandom_range(0, 2) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            t     = 8'($urandom);
            d     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            sclr1 = ($urandom_range(0, 15) == 0);
            en1   = ($urandom_range(0, 3) != 0);
            mode1 = 2'($urandom_range(0, 3));
            t1    = 1'($urandom);
            d1    = 1'($urandom);
        end

        @(negedge clk);
        checkOn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
